adpll_loop_filter: RTL and testbench
====================================

// Module: adpll_loop_filter
// PURPOSE
//  Digital PI loop filter for the ADPLL. Takes signed phase-error samples from the phase detector.
//  Produces the signed DCO control code dco_cc_o. The DCO stage adds that code, sign-extended, to its
//  fixed ring-oscillator bias to form the frequency select. Also tracks loop state and flags lock.
// PARAMETERS
//  PE_WIDTH      8   phase-error width, two's complement
//  ACC_WIDTH     16  integrator width, two's complement, must be > PE_WIDTH
//  DCO_CC_WIDTH  8   output control-code width, two's complement
//  KP_SHIFT      1   proportional gain = err <<< KP_SHIFT
//  KI_SHIFT      4   integral contribution = integ >>> KI_SHIFT (arithmetic)
//  LOCK_TOL      2   |err| <= LOCK_TOL counts as in-tolerance
//  LOCK_COUNT    16  consecutive in-tolerance samples needed to declare lock
// PORTS
//  clk_i          in   1             system clock
//  rst_n_i        in   1             asynchronous, active-low reset
//  en_i           in   1             loop enable; low holds filter idle and cleared
//  freeze_i       in   1             hold integrator; proportional path stays active
//  pe_i           in   PE_WIDTH      signed phase error
//  pe_valid_i     in   1             pe_i valid this cycle, single-cycle strobe
//  dco_cc_o       out  DCO_CC_WIDTH  signed DCO control code, registered
//  dco_cc_valid_o out  1             1-cycle pulse when dco_cc_o updates
//  lock_o         out  1             high while state == LOCKED
// BEHAVIOUR
//  Reset: dco_cc_o=0, dco_cc_valid_o=0, lock_o=0, integrator=0, lock counter=0, state=IDLE.
//  FSM states:
//   - IDLE -> ACQUIRE on the cycle after en_i=1.
//   - ACQUIRE -> LOCKED when the lock counter reaches LOCK_COUNT.
//   - LOCKED -> ACQUIRE on any accepted sample with |err| > LOCK_TOL.
//   - any state -> IDLE on the cycle after en_i=0.
//  IDLE: pe_valid_i ignored. Integrator, counter and dco_cc_o are cleared, so the DCO runs at bias.
//  Sample accepted only when pe_valid_i=1, en_i=1 and state != IDLE.
//  Pipeline, sample accepted at edge N:
//   - Stage 1 (edge N+1): integ <= sat_acc(integ + sext(err)), unless freeze_i=1, then held. err registered.
//   - Stage 2 (edge N+2): dco_cc_o <= sat_cc((err_q <<< KP) + (integ_new >>> KI)).
//     dco_cc_valid_o=1 for that one cycle. lock_o updates on the same edge.
//  Latency 2 cycles. Back-to-back strobes every cycle are supported, fully pipelined.
//  Arithmetic:
//   - All sums are computed at ACC_WIDTH+1 bits.
//   - sat_acc clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
//   - sat_cc clamps to [-2^(DCO_CC_WIDTH-1), 2^(DCO_CC_WIDTH-1)-1]. No wrap-around anywhere.
//  Lock counter: increments per in-tolerance sample, saturating at LOCK_COUNT.
//   Cleared by any out-of-tolerance sample and in IDLE.
//  Simultaneous events:
//   - en_i fall together with pe_valid_i: the sample is dropped, en_i wins.
//     In-flight stage-2 result is discarded, no valid pulse.
//   - freeze_i with pe_valid_i: output updated, integrator unchanged, lock counter still updates.
//  Reset mid-operation: all state clears immediately (async). The pipeline is flushed and no valid pulse is emitted.
// CONFIGURATION
//  ADPLL_GEAR_SHIFT_EN defined: in ACQUIRE the proportional gain is err <<< (KP_SHIFT+1).
//   In LOCKED it is err <<< KP_SHIFT. The gain switches on the edge the state changes.
//  Not defined: err <<< KP_SHIFT in all states.
// STRUCTURE
//  adpll_pkg holds:
//   - typedef enum logic [1:0] {LF_IDLE, LF_ACQUIRE, LF_LOCKED} lf_state_t.
//   - sat_signed() saturation function.
//   - default widths PE_WIDTH / DCO_CC_WIDTH, shared with the phase detector and the DCO.
//  Sub-module adpll_lock_detect: tolerance compare plus lock counter.
//   Inputs err, valid, clear. Output lock_reached.
// TESTING (defaults; "out" = dco_cc_o two cycles after strobe)
//  1. Reset, en_i=1, one sample err=+4 -> integ=4, out=8, single valid pulse; then err=0 -> out=0.
//  2. Ten samples err=+16 -> integ=160, last out=32+10=42; freeze_i=1, err=+16 -> integ stays 160, out=42.
//  3. err=+127 for 300 samples -> integ saturates at 32767, out clamps 127.
//     Then err=-128 repeated -> out clamps -128, no wrap.
//  4. 16 samples err=+1 -> lock_o rises with the 16th output pulse.
//     Then err=+5 -> lock_o falls with that sample's pulse, state ACQUIRE.
//  5. Mid-stream en_i=0 on a strobe cycle -> no valid pulse, out=0, lock_o=0, state IDLE; rst_n_i low mid-pipeline -> same.
//  6. ADPLL_GEAR_SHIFT_EN: err=+4 in ACQUIRE -> out=16+0; after lock, err=+1 -> prop term 2, not 4.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: loop-filter state encoding, common data widths
// and a signed saturation helper used by the loop filter.
package adpll_pkg;

  localparam int ADPLL_PE_WIDTH     = 8;
  localparam int ADPLL_DCO_CC_WIDTH = 8;
  localparam int ADPLL_ACC_WIDTH    = 16;

  typedef enum logic [1:0] {
    LF_IDLE    = 2'd0,
    LF_ACQUIRE = 2'd1,
    LF_LOCKED  = 2'd2
  } lf_state_t;

  // Clamp a signed value into the two's-complement range of i_width bits.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] i_val,
                                                    input int unsigned        i_width);
    logic signed [31:0] w_hi;
    logic signed [31:0] w_lo;
    w_hi = (32'sd1 <<< (i_width - 32'd1)) - 32'sd1;
    w_lo = ~w_hi;
    if (i_val > w_hi) begin
      sat_signed = w_hi;
    end else if (i_val < w_lo) begin
      sat_signed = w_lo;
    end else begin
      sat_signed = i_val;
    end
  endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Lock detector for the ADPLL loop filter: phase-error tolerance compare and
// a saturating counter of consecutive in-tolerance samples.
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int PE_WIDTH   = ADPLL_PE_WIDTH,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_COUNT = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clear,
  input  logic signed [PE_WIDTH-1:0] i_err,
  input  logic                       i_valid,
  output logic                       o_lock_reached,
  output logic                       o_tol_fail
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic signed [PE_WIDTH:0] TOL_S = (PE_WIDTH + 1)'(LOCK_TOL);

  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic signed [PE_WIDTH:0] w_err_ext;
  logic                  w_in_tol;

  // One extra bit keeps -TOL representable and the magnitude compare exact.
  always_comb begin
    w_err_ext = (PE_WIDTH + 1)'(i_err);
    w_in_tol  = (w_err_ext <= TOL_S) && (w_err_ext >= -TOL_S);
  end

  // Next counter value: saturate on in-tolerance, restart on a miss.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clear) begin
      w_cnt_next = '0;
    end else if (i_valid) begin
      if (!w_in_tol) begin
        w_cnt_next = '0;
      end else if (r_cnt == CNT_W'(LOCK_COUNT)) begin
        w_cnt_next = r_cnt;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_lock_reached = (w_cnt_next == CNT_W'(LOCK_COUNT));
  assign o_tol_fail     = i_valid && !w_in_tol && !i_clear;

endmodule

// File: rtl/adpll_loop_filter.sv
// ADPLL digital PI loop filter: two-stage pipeline producing the signed DCO
// control code, plus lock tracking. Optional macro ADPLL_GEAR_SHIFT_EN doubles
// the proportional gain while acquiring.
module adpll_loop_filter
  import adpll_pkg::*;
#(
  parameter int PE_WIDTH     = ADPLL_PE_WIDTH,
  parameter int ACC_WIDTH    = ADPLL_ACC_WIDTH,
  parameter int DCO_CC_WIDTH = ADPLL_DCO_CC_WIDTH,
  parameter int KP_SHIFT     = 1,
  parameter int KI_SHIFT     = 4,
  parameter int LOCK_TOL     = 2,
  parameter int LOCK_COUNT   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           en_i,
  input  logic                           freeze_i,
  input  logic signed [PE_WIDTH-1:0]     pe_i,
  input  logic                           pe_valid_i,
  output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
  output logic                           dco_cc_valid_o,
  output logic                           lock_o
);

  localparam int SUM_W = ACC_WIDTH + 1;

  lf_state_t                       r_state;
  lf_state_t                       w_state_next;
  logic signed [PE_WIDTH-1:0]      r_err;
  logic signed [ACC_WIDTH-1:0]     r_integ;
  logic                            r_s1_valid;
  logic signed [DCO_CC_WIDTH-1:0]  r_dco_cc;
  logic                            r_dco_valid;
  logic                            r_lock;

  logic                            w_accept;
  logic                            w_clear;
  logic signed [SUM_W-1:0]         w_integ_sum;
  logic signed [ACC_WIDTH-1:0]     w_integ_next;
  logic signed [SUM_W-1:0]         w_err_ext;
  logic signed [SUM_W-1:0]         w_prop;
  logic signed [SUM_W-1:0]         w_cc_sum;
  logic signed [DCO_CC_WIDTH-1:0]  w_cc_next;
  logic                            w_lock_reached;
  logic                            w_tol_fail;

  assign w_accept = pe_valid_i && en_i && (r_state != LF_IDLE);
  assign w_clear  = !en_i || (r_state == LF_IDLE);

  // Stage 1 arithmetic: integrator update with saturation.
  always_comb begin
    w_integ_sum  = SUM_W'(r_integ) + SUM_W'(pe_i);
    w_integ_next = ACC_WIDTH'(sat_signed(32'(w_integ_sum), ACC_WIDTH));
  end

  // Stage 2 arithmetic: proportional plus scaled integral, clamped to the code range.
  always_comb begin
    w_err_ext = SUM_W'(r_err);
`ifdef ADPLL_GEAR_SHIFT_EN
    if (r_state == LF_ACQUIRE) begin
      w_prop = w_err_ext <<< (KP_SHIFT + 1);
    end else begin
      w_prop = w_err_ext <<< KP_SHIFT;
    end
`else
    w_prop = w_err_ext <<< KP_SHIFT;
`endif
    w_cc_sum  = w_prop + SUM_W'(r_integ >>> KI_SHIFT);
    w_cc_next = DCO_CC_WIDTH'(sat_signed(32'(w_cc_sum), DCO_CC_WIDTH));
  end

  adpll_lock_detect #(
    .PE_WIDTH   (PE_WIDTH),
    .LOCK_TOL   (LOCK_TOL),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_lock_detect (
    .i_clk          (clk_i),
    .i_rst_n        (rst_n_i),
    .i_clear        (w_clear),
    .i_err          (r_err),
    .i_valid        (r_s1_valid),
    .o_lock_reached (w_lock_reached),
    .o_tol_fail     (w_tol_fail)
  );

  // Loop state next-state logic; lock decisions align with the stage-2 edge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LF_IDLE: begin
        if (en_i) begin
          w_state_next = LF_ACQUIRE;
        end else begin
          w_state_next = LF_IDLE;
        end
      end
      LF_ACQUIRE: begin
        if (!en_i) begin
          w_state_next = LF_IDLE;
        end else if (w_lock_reached) begin
          w_state_next = LF_LOCKED;
        end else begin
          w_state_next = LF_ACQUIRE;
        end
      end
      LF_LOCKED: begin
        if (!en_i) begin
          w_state_next = LF_IDLE;
        end else if (w_tol_fail) begin
          w_state_next = LF_ACQUIRE;
        end else begin
          w_state_next = LF_LOCKED;
        end
      end
      default: begin
        w_state_next = LF_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= LF_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pipeline registers; disabling or idling flushes everything so the DCO sits at bias.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err       <= '0;
      r_integ     <= '0;
      r_s1_valid  <= 1'b0;
      r_dco_cc    <= '0;
      r_dco_valid <= 1'b0;
      r_lock      <= 1'b0;
    end else if (w_clear) begin
      r_err       <= '0;
      r_integ     <= '0;
      r_s1_valid  <= 1'b0;
      r_dco_cc    <= '0;
      r_dco_valid <= 1'b0;
      r_lock      <= 1'b0;
    end else begin
      r_s1_valid  <= w_accept;
      if (w_accept) begin
        r_err <= pe_i;
        if (!freeze_i) begin
          r_integ <= w_integ_next;
        end
      end
      r_dco_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dco_cc <= w_cc_next;
      end
      r_lock      <= (w_state_next == LF_LOCKED);
    end
  end

  assign dco_cc_o       = r_dco_cc;
  assign dco_cc_valid_o = r_dco_valid;
  assign lock_o         = r_lock;

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Scoreboard bench for adpll_loop_filter: directed samples push expected
// outputs; a negedge monitor pops and compares on every valid pulse.
module tb_adpll_loop_filter;
  import adpll_pkg::*;

`ifdef ADPLL_GEAR_SHIFT_EN
  localparam bit GEAR = 1'b1;
`else
  localparam bit GEAR = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              en_i;
  logic              freeze_i;
  logic signed [7:0] pe_i;
  logic              pe_valid_i;
  logic signed [7:0] dco_cc_o;
  logic              dco_cc_valid_o;
  logic              lock_o;

  int checks   = 0;
  int failures = 0;
  int exp_out_q[$];
  bit exp_lock_q[$];
  int last_out = 0;

  int m_integ;
  int m_cnt;
  bit m_locked;

  adpll_loop_filter dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .en_i           (en_i),
    .freeze_i       (freeze_i),
    .pe_i           (pe_i),
    .pe_valid_i     (pe_valid_i),
    .dco_cc_o       (dco_cc_o),
    .dco_cc_valid_o (dco_cc_valid_o),
    .lock_o         (lock_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_n_i && dco_cc_valid_o) begin
      if (exp_out_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=%0d expected=no_pulse", int'(dco_cc_o));
      end else begin
        int eo;
        bit el;
        eo = exp_out_q.pop_front();
        el = exp_lock_q.pop_front();
        check("dco_cc", int'(dco_cc_o), eo);
        check("lock", int'(lock_o), int'(el));
        last_out = int'(dco_cc_o);
      end
    end
  end

  // One accepted sample: update the reference model and queue its expected result.
  task automatic send(input int err, input bit frz);
    int prop;
    int out;
    bit in_tol;
    pe_i       = 8'(err);
    pe_valid_i = 1'b1;
    freeze_i   = frz;
    prop = (GEAR && !m_locked) ? err * 4 : err * 2;
    if (!frz) m_integ = clamp(m_integ + err, -32768, 32767);
    out = clamp(prop + (m_integ >>> 4), -128, 127);
    in_tol = (err <= 2) && (err >= -2);
    m_cnt = in_tol ? ((m_cnt < 16) ? m_cnt + 1 : 16) : 0;
    if (!m_locked && m_cnt == 16) m_locked = 1'b1;
    else if (m_locked && !in_tol) m_locked = 1'b0;
    exp_out_q.push_back(out);
    exp_lock_q.push_back(m_locked);
    @(negedge clk_i);
    pe_valid_i = 1'b0;
    freeze_i   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_out_q.size() != 0; i++) @(negedge clk_i);
    check("drain_empty", exp_out_q.size(), 0);
  endtask

  // Disable then re-enable; a strobe on the enabling cycle hits IDLE and must be ignored.
  task automatic restart();
    en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    en_i       = 1'b1;
    pe_i       = 8'sd50;
    pe_valid_i = 1'b1;
    @(negedge clk_i);
    pe_valid_i = 1'b0;
    @(negedge clk_i);
    m_integ  = 0;
    m_cnt    = 0;
    m_locked = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_i = 1'b0; en_i = 1'b0; freeze_i = 1'b0; pe_i = '0; pe_valid_i = 1'b0;
    m_integ = 0; m_cnt = 0; m_locked = 1'b0;
    #22;
    check("rst_dco", int'(dco_cc_o), 0);
    check("rst_valid", int'(dco_cc_valid_o), 0);
    check("rst_lock", int'(lock_o), 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // 1: single sample then zero error
    restart();
    send(4, 1'b0);
    drain();
    check("t1_out", last_out, GEAR ? 16 : 8);
    send(0, 1'b0);
    drain();
    check("t1_zero", last_out, 0);

    // 2: integration and freeze
    restart();
    for (int i = 0; i < 10; i++) send(16, 1'b0);
    drain();
    check("t2_out", last_out, GEAR ? 74 : 42);
    send(16, 1'b1);
    drain();
    check("t2_freeze_out", last_out, GEAR ? 74 : 42);
    check("t2_freeze_integ", int'(dut.r_integ), 160);
    send(0, 1'b0);
    drain();
    check("t2_after_freeze", last_out, 10);

    // 3: saturation both ways
    restart();
    for (int i = 0; i < 300; i++) send(127, 1'b0);
    drain();
    check("t3_integ_hi", int'(dut.r_integ), 32767);
    check("t3_out_hi", last_out, 127);
    for (int i = 0; i < 600; i++) send(-128, 1'b0);
    drain();
    check("t3_integ_lo", int'(dut.r_integ), -32768);
    check("t3_out_lo", last_out, -128);

    // 4: lock acquisition and loss
    restart();
    for (int i = 0; i < 16; i++) send(1, 1'b0);
    drain();
    check("t4_locked", int'(lock_o), 1);
    check("t4_out16", last_out, GEAR ? 5 : 3);
    send(1, 1'b0);
    drain();
    check("t4_locked_prop", last_out, 3);
    send(5, 1'b0);
    drain();
    check("t4_unlock_out", last_out, 11);
    check("t4_unlocked", int'(lock_o), 0);
    check("t4_state", int'(dut.r_state), int'(LF_ACQUIRE));

    // 5a: enable drop on a strobe cycle while locked
    restart();
    for (int i = 0; i < 16; i++) send(0, 1'b0);
    drain();
    check("t5_locked", int'(lock_o), 1);
    pe_i = 8'sd5; pe_valid_i = 1'b1;
    @(negedge clk_i);
    en_i = 1'b0; pe_i = 8'sd7;
    @(negedge clk_i);
    pe_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("t5_en_out", int'(dco_cc_o), 0);
    check("t5_en_lock", int'(lock_o), 0);
    check("t5_en_state", int'(dut.r_state), int'(LF_IDLE));

    // 5b: async reset with a sample in flight
    restart();
    pe_i = 8'sd9; pe_valid_i = 1'b1;
    @(negedge clk_i);
    pe_valid_i = 1'b0;
    #2 rst_n_i = 1'b0;
    @(negedge clk_i);
    check("t5_rst_out", int'(dco_cc_o), 0);
    check("t5_rst_lock", int'(lock_o), 0);
    check("t5_rst_state", int'(dut.r_state), int'(LF_IDLE));
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    restart();
    send(4, 1'b0);
    drain();
    check("t5_recover", last_out, GEAR ? 16 : 8);

    check("final_queue", exp_out_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
